// File: rtl/wb_merge_arbiter.sv
// wb_merge_arbiter: buffered multi-port GPR writeback merger.
// Each of NCH producers feeds a DEPTH-entry FIFO. Up to NPORT FIFO heads
// retire per cycle, picked round-robin. A head that targets the same
// register as an earlier grant in the same cycle is skipped.
// Optional build macro WB_HAZARD_EN adds a per-register pending-write
// counter that drives the busy bitmap; without it busy is tied to zero.
module wb_merge_arbiter #(
  parameter int NCH    = 8,
  parameter int NPORT  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           interlock,
  input  logic [NCH-1:0]                 in_valid,
  output logic [NCH-1:0]                 in_ready,
  input  logic [NCH*ADDR_W-1:0]          in_rt,
  input  logic [NCH*DATA_W-1:0]          in_data,
  output logic [NPORT-1:0]               wr_en,
  output logic [NPORT*ADDR_W-1:0]        wr_addr,
  output logic [NPORT*DATA_W-1:0]        wr_data,
  output logic [$clog2(NCH*DEPTH+1)-1:0] pending,
  output logic [(2**ADDR_W)-1:0]         busy
);
  localparam int PEND_W = $clog2(NCH*DEPTH+1);
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int PORT_W = $clog2(NPORT+1);
  localparam int NREG   = 2**ADDR_W;

  // FIFO storage and state
  logic [ADDR_W-1:0] rt_mem_r    [NCH][DEPTH];
  logic [DATA_W-1:0] data_mem_r  [NCH][DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r    [NCH];
  logic [PTR_W-1:0]  wr_ptr_r    [NCH];
  logic [CNT_W-1:0]  cnt_r       [NCH];
  logic [CNT_W-1:0]  cnt_nxt_s   [NCH];
  logic [NCH-1:0]    ready_r;
  logic [NCH-1:0]    push_s;
  logic [NCH-1:0]    pop_s;
  logic [ADDR_W-1:0] head_rt_s   [NCH];
  logic [DATA_W-1:0] head_data_s [NCH];

  // Arbitration
  logic [CH_W-1:0]   rr_r;
  logic [CH_W-1:0]   rr_nxt_s;
  logic [CH_W:0]     arb_pos_s;
  logic [CH_W:0]     arb_nxt_s;
  logic [CH_W-1:0]   arb_idx_s;
  logic              arb_clash_s;
  logic [PORT_W-1:0] n_grant_s;
  logic [ADDR_W-1:0] port_rt_s   [NPORT];
  logic [DATA_W-1:0] port_data_s [NPORT];

  // Output registers
  logic [PEND_W-1:0]       pending_r;
  logic [PEND_W-1:0]       pend_nxt_s;
  logic [NPORT-1:0]        wr_en_r;
  logic [NPORT*ADDR_W-1:0] wr_addr_r;
  logic [NPORT*DATA_W-1:0] wr_data_r;

  assign in_ready = ready_r;
  assign wr_en    = wr_en_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;
  assign pending  = pending_r;

  // Qualify enqueues (rt 0 completes the handshake but is dropped) and read FIFO heads
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      push_s[c]      = in_valid[c] & ready_r[c] & (in_rt[c*ADDR_W +: ADDR_W] != {ADDR_W{1'b0}});
      head_rt_s[c]   = rt_mem_r[c][rd_ptr_r[c]];
      head_data_s[c] = data_mem_r[c][rd_ptr_r[c]];
    end
  end

  // Round-robin scan from rr; grant heads to ports in order, skipping same-rt repeats
  always_comb begin
    pop_s       = {NCH{1'b0}};
    n_grant_s   = {PORT_W{1'b0}};
    rr_nxt_s    = rr_r;
    arb_pos_s   = {(CH_W+1){1'b0}};
    arb_nxt_s   = {(CH_W+1){1'b0}};
    arb_idx_s   = {CH_W{1'b0}};
    arb_clash_s = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      port_rt_s[p]   = {ADDR_W{1'b0}};
      port_data_s[p] = {DATA_W{1'b0}};
    end
    for (int k = 0; k < NCH; k++) begin
      arb_pos_s = {1'b0, rr_r} + (CH_W+1)'(k);
      if (arb_pos_s >= (CH_W+1)'(NCH)) begin
        arb_pos_s = arb_pos_s - (CH_W+1)'(NCH);
      end else begin
        arb_pos_s = arb_pos_s;
      end
      arb_idx_s = arb_pos_s[CH_W-1:0];
      arb_nxt_s = arb_pos_s + (CH_W+1)'(1);
      if (arb_nxt_s >= (CH_W+1)'(NCH)) begin
        arb_nxt_s = {(CH_W+1){1'b0}};
      end else begin
        arb_nxt_s = arb_nxt_s;
      end
      arb_clash_s = 1'b0;
      for (int p = 0; p < NPORT; p++) begin
        if ((PORT_W'(p) < n_grant_s) && (port_rt_s[p] == head_rt_s[arb_idx_s])) begin
          arb_clash_s = 1'b1;
        end else begin
          arb_clash_s = arb_clash_s;
        end
      end
      if (!interlock && (cnt_r[arb_idx_s] != {CNT_W{1'b0}}) &&
          (n_grant_s < PORT_W'(NPORT)) && !arb_clash_s) begin
        pop_s[arb_idx_s] = 1'b1;
        for (int p = 0; p < NPORT; p++) begin
          if (PORT_W'(p) == n_grant_s) begin
            port_rt_s[p]   = head_rt_s[arb_idx_s];
            port_data_s[p] = head_data_s[arb_idx_s];
          end else begin
            port_rt_s[p]   = port_rt_s[p];
            port_data_s[p] = port_data_s[p];
          end
        end
        n_grant_s = n_grant_s + PORT_W'(1);
        rr_nxt_s  = arb_nxt_s[CH_W-1:0];
      end else begin
        n_grant_s = n_grant_s;
      end
    end
  end

  // Next occupancy per channel and total buffered-entry count
  always_comb begin
    pend_nxt_s = pending_r;
    for (int c = 0; c < NCH; c++) begin
      cnt_nxt_s[c] = cnt_r[c] + CNT_W'(push_s[c]) - CNT_W'(pop_s[c]);
      pend_nxt_s   = pend_nxt_s + PEND_W'(push_s[c]) - PEND_W'(pop_s[c]);
    end
  end

  // FIFO payload storage; slot contents are ignored while the slot is empty
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (push_s[c]) begin
        rt_mem_r[c][wr_ptr_r[c]]   <= in_rt[c*ADDR_W +: ADDR_W];
        data_mem_r[c][wr_ptr_r[c]] <= in_data[c*DATA_W +: DATA_W];
      end
    end
  end

  // FIFO pointers, occupancy and registered ready (full stays not-ready even while popping)
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int c = 0; c < NCH; c++) begin
        cnt_r[c]    <= {CNT_W{1'b0}};
        rd_ptr_r[c] <= {PTR_W{1'b0}};
        wr_ptr_r[c] <= {PTR_W{1'b0}};
      end
      ready_r <= {NCH{1'b0}};
    end else begin
      for (int c = 0; c < NCH; c++) begin
        cnt_r[c]   <= cnt_nxt_s[c];
        ready_r[c] <= (cnt_nxt_s[c] < CNT_W'(DEPTH));
        if (push_s[c]) begin
          wr_ptr_r[c] <= wr_ptr_r[c] + PTR_W'(1);
        end else begin
          wr_ptr_r[c] <= wr_ptr_r[c];
        end
        if (pop_s[c]) begin
          rd_ptr_r[c] <= rd_ptr_r[c] + PTR_W'(1);
        end else begin
          rd_ptr_r[c] <= rd_ptr_r[c];
        end
      end
    end
  end

  // Round-robin pointer, pending count and registered GPR write ports
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_r      <= {CH_W{1'b0}};
      pending_r <= {PEND_W{1'b0}};
      wr_en_r   <= {NPORT{1'b0}};
      wr_addr_r <= {(NPORT*ADDR_W){1'b0}};
      wr_data_r <= {(NPORT*DATA_W){1'b0}};
    end else begin
      rr_r      <= rr_nxt_s;
      pending_r <= pend_nxt_s;
      for (int p = 0; p < NPORT; p++) begin
        if (PORT_W'(p) < n_grant_s) begin
          wr_en_r[p]                   <= 1'b1;
          wr_addr_r[p*ADDR_W +: ADDR_W] <= port_rt_s[p];
          wr_data_r[p*DATA_W +: DATA_W] <= port_data_s[p];
        end else begin
          wr_en_r[p] <= 1'b0;
        end
      end
    end
  end

`ifdef WB_HAZARD_EN
  logic [PEND_W-1:0] hz_cnt_r [NREG];
  logic [PEND_W-1:0] hz_nxt_s [NREG];
  logic [NREG-1:0]   busy_r;

  assign busy = busy_r;

  // Net per-register change: enqueues targeting r minus retirements of r
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      hz_nxt_s[r] = hz_cnt_r[r];
      for (int c = 0; c < NCH; c++) begin
        if (push_s[c] && (in_rt[c*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
          hz_nxt_s[r] = hz_nxt_s[r] + PEND_W'(1);
        end else begin
          hz_nxt_s[r] = hz_nxt_s[r];
        end
      end
      for (int p = 0; p < NPORT; p++) begin
        if ((PORT_W'(p) < n_grant_s) && (port_rt_s[p] == ADDR_W'(r))) begin
          hz_nxt_s[r] = hz_nxt_s[r] - PEND_W'(1);
        end else begin
          hz_nxt_s[r] = hz_nxt_s[r];
        end
      end
    end
  end

  // Per-register pending counters and the registered busy bitmap
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int r = 0; r < NREG; r++) begin
        hz_cnt_r[r] <= {PEND_W{1'b0}};
      end
      busy_r <= {NREG{1'b0}};
    end else begin
      for (int r = 0; r < NREG; r++) begin
        hz_cnt_r[r] <= hz_nxt_s[r];
        busy_r[r]   <= (hz_nxt_s[r] != {PEND_W{1'b0}});
      end
    end
  end
`else
  assign busy = {NREG{1'b0}};
`endif

endmodule
